// File: rtl/rv32i_lsu_if.sv
// ----------------------------------------------------------------------------
// rv32i_lsu_if -- data-RAM port between the RV32I load/store unit and the RAM.
//
//   d_addr  [29:0]  word address (byte address [31:2])
//   d_be    [3:0]   byte-lane enables
//   d_we            write strobe
//   d_wdata [31:0]  lane-positioned store data
//   d_rdata [31:0]  read data, valid one cycle after d_addr
//
// master: the load/store unit.  slave: the RAM.
// ----------------------------------------------------------------------------
interface rv32i_lsu_if;
    logic [29:0] d_addr;
    logic [3:0]  d_be;
    logic        d_we;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;

    modport master (
        output d_addr, d_be, d_we, d_wdata,
        input  d_rdata
    );

    modport slave (
        input  d_addr, d_be, d_we, d_wdata,
        output d_rdata
    );
endinterface

// File: rtl/rv32i_lsu.sv
// ----------------------------------------------------------------------------
// rv32i_lsu -- single-cycle RV32I load/store unit (MEM stage).
//
// Drives the data RAM combinationally from the EX-stage operands, registers
// the pipeline payload for one cycle, and aligns / extends the RAM read data
// in the following cycle.  Misaligned accesses are suppressed and raise a
// sticky error flag; illegal funct3 encodings are suppressed silently.
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   iw_in, pc_in        instruction word / PC from EX
//   alu_in              effective address (or ALU result)
//   rs2_data_in         store source data
//   wb_en_in            writeback enable from EX
//   mem                 data-RAM port (rv32i_lsu_if.master)
//   iw_out, pc_out,
//   alu_out             registered copies of the EX payload
//   wb_en_out           registered writeback enable (killed for bad loads)
//   load_out            registered "instruction is a load"
//   load_data_out       aligned, extended load value
//   misalign_err        sticky misaligned-access flag
// ----------------------------------------------------------------------------
module rv32i_lsu (
    input  logic               clk,
    input  logic               reset,
    input  logic [31:0]        iw_in,
    input  logic [31:0]        pc_in,
    input  logic [31:0]        alu_in,
    input  logic [31:0]        rs2_data_in,
    input  logic               wb_en_in,
    rv32i_lsu_if.master        mem,
    output logic [31:0]        iw_out,
    output logic [31:0]        pc_out,
    output logic [31:0]        alu_out,
    output logic               wb_en_out,
    output logic               load_out,
    output logic [31:0]        load_data_out,
    output logic               misalign_err
);

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    // Loads accept LB/LH/LW/LBU/LHU; every other funct3 is illegal.
    function automatic logic load_f3_ok(input logic [2:0] f3);
        return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
               (f3 == 3'b100) || (f3 == 3'b101);
    endfunction

    // funct3[1:0] encodes the access size; bytes are never misaligned.
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b01:   return off[0];
            2'b10:   return off != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Decode of the access presented this cycle
    // ------------------------------------------------------------------
    logic [2:0] funct3;
    logic       is_load, is_store, load_ok, store_ok, misaligned;

    assign funct3     = iw_in[14:12];
    assign is_load    = iw_in[6:0] == OPC_LOAD;
    assign is_store   = iw_in[6:0] == OPC_STORE;
    assign load_ok    = is_load && load_f3_ok(funct3);
    assign store_ok   = is_store && !funct3[2] && (funct3[1:0] != 2'b11);
    // Illegal encodings never count as misaligned.
    assign misaligned = (load_ok || store_ok) && is_misaligned(funct3, alu_in[1:0]);

    // ------------------------------------------------------------------
    // RAM request (combinational)
    // ------------------------------------------------------------------
    assign mem.d_addr = alu_in[31:2];

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case/if tree can leave it unassigned and infer a latch.
    always_comb begin
        mem.d_we = 1'b0;
        mem.d_be = 4'b0000;
        if (!reset && !misaligned) begin
            if (store_ok) begin
                mem.d_we = 1'b1;
                case (funct3[1:0])
                    2'b00:   mem.d_be = 4'b0001 << alu_in[1:0];
                    2'b01:   mem.d_be = alu_in[1] ? 4'b1100 : 4'b0011;
                    default: mem.d_be = 4'b1111;
                endcase
            end else if (load_ok) begin
                mem.d_be = 4'b1111;
            end
        end
    end

    always_comb begin
        case (funct3[1:0])
            2'b00:   mem.d_wdata = {4{rs2_data_in[7:0]}};
            2'b01:   mem.d_wdata = {2{rs2_data_in[15:0]}};
            default: mem.d_wdata = rs2_data_in;
        endcase
    end

    // ------------------------------------------------------------------
    // Pipeline registers
    // ------------------------------------------------------------------
    logic [31:0] iw_q, pc_q, alu_q;
    logic        wb_en_q, wb_en_d;
    logic        load_q;
    logic        err_q, err_d;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;

    // A load that will not produce data must not write the register file.
    assign wb_en_d = wb_en_in && !(is_load && (!load_ok || misaligned));
    assign err_d   = err_q || misaligned;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of the others, independent of statement order.
    // NOTE: the reset here is synchronous and covers only a handful of flops;
    // there is no storage array in this block that would need clearing.
    always_ff @(posedge clk) begin
        if (reset) begin
            iw_q    <= '0;
            pc_q    <= '0;
            alu_q   <= '0;
            wb_en_q <= 1'b0;
            load_q  <= 1'b0;
            err_q   <= 1'b0;
            f3_q    <= '0;
            off_q   <= '0;
        end else begin
            iw_q    <= iw_in;
            pc_q    <= pc_in;
            alu_q   <= alu_in;
            wb_en_q <= wb_en_d;
            load_q  <= is_load;
            err_q   <= err_d;
            f3_q    <= funct3;
            off_q   <= alu_in[1:0];
        end
    end

    assign iw_out       = iw_q;
    assign pc_out       = pc_q;
    assign alu_out      = alu_q;
    assign wb_en_out    = wb_en_q;
    assign load_out     = load_q;
    assign misalign_err = err_q;

    // ------------------------------------------------------------------
    // Load aligner (cycle N+1, from registered funct3/offset)
    // ------------------------------------------------------------------
    logic        ld_valid;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign ld_valid = load_q && load_f3_ok(f3_q) && !is_misaligned(f3_q, off_q);
    assign byte_sel = mem.d_rdata[8*off_q +: 8];
    assign half_sel = off_q[1] ? mem.d_rdata[31:16] : mem.d_rdata[15:0];

    always_comb begin
        load_data_out = '0;
        if (ld_valid) begin
            case (f3_q)
                3'b000:  load_data_out = {{24{byte_sel[7]}}, byte_sel};
                3'b100:  load_data_out = {24'h0, byte_sel};
                3'b001:  load_data_out = {{16{half_sel[15]}}, half_sel};
                3'b101:  load_data_out = {16'h0, half_sel};
                3'b010:  load_data_out = mem.d_rdata;
                default: load_data_out = '0;
            endcase
        end
    end

endmodule

// File: doc/rv32i_lsu.md
RV32I_LSU -- requirements
Module: rv32i_lsu

Interface
REQ-001 SHALL have ports: clk  in  1  clock; all state updates on rising edge.
REQ-002 SHALL have ports: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have ports: iw_in  in  32  instruction word from EX; pc_in  in  32  PC from EX.
REQ-004 SHALL have ports: alu_in  in  32  effective address or ALU result; rs2_data_in  in  32  store source data; wb_en_in  in  1  writeback enable from EX.
REQ-005 SHALL have ports: d_addr  out  30  RAM word address [31:2]; d_be  out  4  byte enables; d_we  out  1  write strobe; d_wdata  out  32  lane-positioned store data.
REQ-006 SHALL have ports: d_rdata  in  32  RAM read data, valid one cycle after d_addr.
REQ-007 SHALL have ports: iw_out, pc_out, alu_out  out  32 each  registered copies; wb_en_out  out  1; load_out  out  1  registered "instruction is a load"; load_data_out  out  32  aligned, extended load value; misalign_err  out  1  sticky error flag.

Function
REQ-008 SHALL decode load as iw_in[6:0]=0000011, store as 0100011; size/sign from iw_in[14:12].
REQ-009 SHALL drive d_addr=alu_in[31:2] combinationally in every cycle, regardless of instruction type.
REQ-010 SHALL drive d_we=1 only for a store that is aligned, has a legal funct3 and reset=0; otherwise d_we=0 and d_be=0000.
REQ-011 SHALL form d_be: SB 0001<<alu_in[1:0]; SH alu_in[1]?1100:0011; SW 1111; loads 1111 with d_we=0.
REQ-012 SHALL form d_wdata: SB rs2[7:0] replicated x4; SH rs2[15:0] replicated x2; SW rs2 unchanged.
REQ-013 SHALL treat as misaligned: halfword with alu_in[0]=1; word with alu_in[1:0]!=00. Byte access is never misaligned.
REQ-014 SHALL treat store funct3 011-111 and load funct3 011,110,111 as illegal: no write, load result 0, wb_en suppressed for the load, no misalign_err.
REQ-015 SHALL register each cycle (1-cycle latency): iw_out<=iw_in, pc_out<=pc_in, alu_out<=alu_in, load_out<=is_load, plus internal funct3 and alu_in[1:0] for the load aligner.
REQ-016 SHALL register wb_en_out<=wb_en_in AND NOT (load AND (misaligned OR illegal)); stores pass wb_en_in unchanged.
REQ-017 SHALL compute load_data_out combinationally in cycle N+1 from d_rdata and registered funct3/offset: LB/LBU select byte at offset, sign/zero-extend; LH/LHU select half by offset[1], sign/zero-extend; LW pass through.
REQ-018 SHALL drive load_data_out=0 when load_out=0 or the registered load was misaligned or illegal.
REQ-019 SHALL set misalign_err=1 on the edge after any misaligned load or store; it SHALL remain 1 until reset.
REQ-020 SHALL handle back-to-back accesses every cycle with no stall; a load immediately after a store to the same word returns RAM read-during-write behaviour unmodified (no forwarding).

Reset
REQ-021 SHALL, while reset=1, force d_we=0 and d_be=0000 combinationally.
REQ-022 SHALL, on a clock edge with reset=1, clear iw_out, pc_out, alu_out, wb_en_out, load_out, misalign_err and internal funct3/offset to 0; load_data_out therefore reads 0.
REQ-023 SHALL discard any access presented in the cycle reset is asserted; the first valid access is the one presented in the cycle after reset deasserts.

Verification
REQ-024 SB: alu_in=0x0000_1003, rs2=0x1234_56AB -> d_addr=0x400, d_be=1000, d_wdata=0xABAB_ABAB, d_we=1.
REQ-025 SH misaligned: alu_in=0x0000_1001, funct3=001 -> d_we=0, d_be=0000; next cycle misalign_err=1, stays 1 over 10 further clean accesses.
REQ-026 LB/LBU: alu_in offset 2, d_rdata=0x0080_0000 in N+1 -> LB load_data_out=0xFFFF_FF80; LBU 0x0000_0080; wb_en_out=1.
REQ-027 LH: offset 2, d_rdata=0x8001_7FFF -> 0xFFFF_8001; LHU 0x0000_8001; LW offset 1 -> wb_en_out=0, load_data_out=0, misalign_err=1.
REQ-028 Back-to-back SW 0xDEAD_BEEF to 0x20 then LW 0x20 in consecutive cycles: store d_we=1 cycle N, load d_we=0 cycle N+1, no dropped cycle; registered outputs follow inputs by exactly 1 cycle.
REQ-029 Reset mid-stream: assert reset while an SW is presented -> d_we=0 that cycle; after edge all registered outputs and misalign_err read 0.
